// File: rtl/ber_sync_counter.sv
// ============================================================================
//  Module   : ber_sync_counter
//  Function : Bit-error-rate checker for one PRBS rail. Scans MAX_DELAY
//             reference-to-received offsets over WINDOW enables each, locks on
//             the offset with the fewest errors (if within ERR_THRESH), then
//             accumulates saturating bit and error counts.
//  Options  : define BER_RELOCK_EN to drop lock and rescan when a locked
//             window sees more than ERR_THRESH errors.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ber_sync_counter #(
  parameter int MAX_DELAY  = 16,
  parameter int WINDOW     = 128,
  parameter int ERR_THRESH = 0,
  parameter int CNT_W      = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_enable,
  input  logic                         i_ref,
  input  logic                         i_rx,
  input  logic                         i_clear,
  output logic                         o_locked,
  output logic [$clog2(MAX_DELAY)-1:0] o_delay,
  output logic [CNT_W-1:0]             o_bit_count,
  output logic [CNT_W-1:0]             o_err_count,
  output logic                         o_error_flag
);

  localparam int DW  = $clog2(MAX_DELAY);
  localparam int WCW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  // One spare code so the "no best yet" marker is always above any window sum
  localparam int EW  = $clog2(WINDOW + 2);

  localparam logic [WCW-1:0]   c_win_last = WCW'(WINDOW - 1);
  localparam logic [DW-1:0]    c_d_last   = DW'(MAX_DELAY - 1);
  localparam logic [CNT_W-1:0] c_cnt_max  = '1;
  localparam logic [EW-1:0]    c_err_init = '1;
  localparam logic [31:0]      c_thresh   = 32'(ERR_THRESH);

  typedef enum logic {
    ST_SCAN = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t                 state_q;
  logic [MAX_DELAY-2:0]   dl_q;
  logic [MAX_DELAY-2:0]   dl_d;
  logic [DW-1:0]          d_q;
  logic [WCW-1:0]         win_cnt_q;
  logic [EW-1:0]          win_err_q;
  logic [EW-1:0]          best_err_q;
  logic [DW-1:0]          best_d_q;
  logic                   locked_q;
  logic [DW-1:0]          delay_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [CNT_W-1:0]       err_cnt_q;
  logic                   flag_q;

  logic [MAX_DELAY-1:0]   w_taps;
  logic                   w_scan_mis;
  logic                   w_lock_mis;
  logic                   w_mis;
  logic [EW-1:0]          w_win_sum;
  logic                   w_win_end;
  logic                   w_better;
  logic [EW-1:0]          w_best_err;
  logic [DW-1:0]          w_best_d;
  logic                   w_lock_ok;

  // Tap selection, running window sum and best-candidate bookkeeping
  always_comb begin
    // Tap 0 is the live reference, tap k is the reference k enables ago
    w_taps     = {dl_q, i_ref};
    dl_d       = w_taps[MAX_DELAY-2:0];
    w_scan_mis = w_taps[d_q] ^ i_rx;
    w_lock_mis = w_taps[delay_q] ^ i_rx;
    w_mis      = (state_q == ST_LOCK) ? w_lock_mis : w_scan_mis;
    // Window total including the mismatch on the current enable
    w_win_sum  = win_err_q + EW'(w_mis);
    w_win_end  = (win_cnt_q == c_win_last);
    // Strictly-less keeps the lowest offset on ties
    w_better   = (w_win_sum < best_err_q);
    w_best_err = w_better ? w_win_sum : best_err_q;
    w_best_d   = w_better ? d_q : best_d_q;
    w_lock_ok  = (32'(w_best_err) <= c_thresh);
  end

`ifdef BER_RELOCK_EN
  logic w_relock;
  assign w_relock = (32'(w_win_sum) > c_thresh);
`endif

  // Reference delay line; shifts on every enable, even during a clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dl_q <= '0;
    end else if (i_enable) begin
      dl_q <= dl_d;
    end
  end

  // Scan/lock state machine with registered outputs and counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_SCAN;
      d_q        <= '0;
      win_cnt_q  <= '0;
      win_err_q  <= '0;
      best_err_q <= c_err_init;
      best_d_q   <= '0;
      locked_q   <= 1'b0;
      delay_q    <= '0;
      bit_cnt_q  <= '0;
      err_cnt_q  <= '0;
      flag_q     <= 1'b0;
    end else if (i_clear) begin
      // Clear wins over a coincident enable and restarts the search
      state_q    <= ST_SCAN;
      d_q        <= '0;
      win_cnt_q  <= '0;
      win_err_q  <= '0;
      best_err_q <= c_err_init;
      best_d_q   <= '0;
      locked_q   <= 1'b0;
      delay_q    <= '0;
      bit_cnt_q  <= '0;
      err_cnt_q  <= '0;
      flag_q     <= 1'b0;
    end else if (i_enable) begin
      case (state_q)
        ST_SCAN: begin
          if (w_win_end) begin
            win_cnt_q <= '0;
            win_err_q <= '0;
            if (d_q == c_d_last) begin
              // Whole offset range visited: lock or start over
              d_q        <= '0;
              best_err_q <= c_err_init;
              best_d_q   <= '0;
              if (w_lock_ok) begin
                state_q  <= ST_LOCK;
                locked_q <= 1'b1;
                delay_q  <= w_best_d;
              end
            end else begin
              d_q        <= d_q + DW'(1);
              best_err_q <= w_best_err;
              best_d_q   <= w_best_d;
            end
          end else begin
            win_cnt_q <= win_cnt_q + WCW'(1);
            win_err_q <= w_win_sum;
          end
        end

        ST_LOCK: begin
          if (bit_cnt_q != c_cnt_max) begin
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          end
          if (w_lock_mis) begin
            flag_q <= 1'b1;
            if (err_cnt_q != c_cnt_max) begin
              err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
          end
`ifdef BER_RELOCK_EN
          // Monitor link quality per window; a bad window forces a rescan
          if (w_win_end) begin
            win_cnt_q <= '0;
            win_err_q <= '0;
            if (w_relock) begin
              state_q    <= ST_SCAN;
              d_q        <= '0;
              best_err_q <= c_err_init;
              best_d_q   <= '0;
              locked_q   <= 1'b0;
              delay_q    <= '0;
              bit_cnt_q  <= '0;
              err_cnt_q  <= '0;
              flag_q     <= 1'b0;
            end
          end else begin
            win_cnt_q <= win_cnt_q + WCW'(1);
            win_err_q <= w_win_sum;
          end
`endif
        end

        default: begin
          state_q <= ST_SCAN;
        end
      endcase
    end
  end

  assign o_locked     = locked_q;
  assign o_delay      = delay_q;
  assign o_bit_count  = bit_cnt_q;
  assign o_err_count  = err_cnt_q;
  assign o_error_flag = flag_q;

endmodule

`default_nettype wire

// File: tb/tb_ber_sync_counter.sv
// ============================================================================
//  Module   : tb_ber_sync_counter
//  Function : Randomised bench for ber_sync_counter (default build and
//             BER_RELOCK_EN build) against a behavioural scan/lock model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ber_sync_counter;

  localparam int MAXD = 16;
  localparam int WIN  = 128;
  localparam int THR  = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_enable = 1'b0;
  logic i_ref = 1'b0;
  logic i_rx = 1'b0;
  logic i_clear = 1'b0;

  logic        o_locked, o_error_flag;
  logic [3:0]  o_delay;
  logic [31:0] o_bit_count, o_err_count;
  logic        o_locked4, o_error_flag4;
  logic [3:0]  o_delay4;
  logic [3:0]  o_bit_count4, o_err_count4;

  always #5 clk = ~clk;

  ber_sync_counter dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_ref(i_ref), .i_rx(i_rx),
    .i_clear(i_clear), .o_locked(o_locked), .o_delay(o_delay),
    .o_bit_count(o_bit_count), .o_err_count(o_err_count),
    .o_error_flag(o_error_flag)
  );

  ber_sync_counter #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_ref(i_ref), .i_rx(i_rx),
    .i_clear(i_clear), .o_locked(o_locked4), .o_delay(o_delay4),
    .o_bit_count(o_bit_count4), .o_err_count(o_err_count4),
    .o_error_flag(o_error_flag4)
  );

  logic [83:0] obs;
  assign obs = {o_locked, o_delay, o_bit_count, o_err_count, o_error_flag,
                o_locked4, o_delay4, o_bit_count4, o_err_count4, o_error_flag4};

  // ---------------- stimulus generator and reference model ----------------
  logic [63:0] hist;            // reference bits, most recent in bit 0
  int     m_err[MAXD];          // per-offset error totals of the current scan
  int     m_n;                  // enables into the current scan
  bit     m_locked;
  int     m_delay;
  longint m_bit, m_errc;
  int     m_bit4, m_err4;
  bit     m_flag;
  int     m_ln, m_le;           // locked-window enable/error tallies
  int     tx_delay;
  bit     rx_invert, rx_flip;
  int     vectors, miscompares;

  function automatic bit ref_at(input int d, input bit r);
    return (d == 0) ? r : hist[d-1];
  endfunction

  function automatic void model_clear();
    m_n = 0; m_locked = 0; m_delay = 0; m_bit = 0; m_errc = 0;
    m_bit4 = 0; m_err4 = 0; m_flag = 0; m_ln = 0; m_le = 0;
    foreach (m_err[d]) m_err[d] = 0;
  endfunction

  function automatic void model_step(input bit clr, input bit r, input bit x);
    bit mis;
    if (clr) begin
      model_clear();
    end else if (!m_locked) begin
      int c = m_n / WIN;
      m_err[c] += int'(x ^ ref_at(c, r));
      m_n++;
      if (m_n == MAXD * WIN) begin
        int best = 0;
        for (int d = 1; d < MAXD; d++) if (m_err[d] < m_err[best]) best = d;
        if (m_err[best] <= THR) begin
          m_locked = 1;
          m_delay  = best;
        end
        m_n = 0;
        foreach (m_err[d]) m_err[d] = 0;
      end
    end else begin
      mis = x ^ ref_at(m_delay, r);
      if (m_bit < 64'hFFFF_FFFF) m_bit++;
      if (m_bit4 < 15) m_bit4++;
      if (mis) begin
        m_flag = 1;
        if (m_errc < 64'hFFFF_FFFF) m_errc++;
        if (m_err4 < 15) m_err4++;
      end
`ifdef BER_RELOCK_EN
      m_le += int'(mis);
      m_ln++;
      if (m_ln == WIN) begin
        if (m_le > THR) model_clear();
        m_ln = 0;
        m_le = 0;
      end
`endif
    end
    hist = {hist[62:0], r};
  endfunction

  function automatic logic [83:0] expv();
    return {m_locked, 4'(m_delay), 32'(m_bit), 32'(m_errc), m_flag,
            m_locked, 4'(m_delay), 4'(m_bit4), 4'(m_err4), m_flag};
  endfunction

  // One enable after gap-1 idle clocks; optionally with a coincident clear
  task automatic en_step(input int gap, input bit clr);
    bit r, x;
    repeat (gap - 1) @(negedge clk);
    @(negedge clk);
    r = 1'($urandom_range(0, 1));
    x = ref_at(tx_delay, r) ^ rx_invert ^ rx_flip;
    rx_flip = 0;
    i_enable = 1'b1; i_ref = r; i_rx = x; i_clear = clr;
    model_step(clr, r, x);
    @(posedge clk);
    #1;
    i_enable = 1'b0; i_clear = 1'b0;
  endtask

  // ------------------------------- tests ----------------------------------
  task automatic test_reset();
    rst = 1'b0;
    hist = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (obs !== 84'h0) begin
      miscompares++;
      $display("FAIL reset_state: got %h, expected 0", obs);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (obs !== expv()) begin
      miscompares++;
      $display("FAIL reset_release: got %h, expected %h", obs, expv());
    end
  endtask

  task automatic test_scan_lock();
    tx_delay = 5; rx_invert = 0;
    for (int i = 0; i < MAXD * WIN; i++) begin
      en_step(4, 0);
      vectors++;
      if (obs !== expv()) begin
        miscompares++;
        $display("FAIL scan_lock enable %0d: got %h, expected %h", i, obs, expv());
      end
    end
    vectors++;
    if ({o_locked, o_delay} !== {1'b1, 4'd5}) begin
      miscompares++;
      $display("FAIL lock_at_2048: got locked=%b delay=%0d, expected locked=1 delay=5",
               o_locked, o_delay);
    end
    for (int i = 0; i < 100; i++) begin
      en_step($urandom_range(1, 4), 0);
      vectors++;
      if (obs !== expv()) begin
        miscompares++;
        $display("FAIL count_clean enable %0d: got %h, expected %h", i, obs, expv());
      end
    end
    vectors++;
    if (o_bit_count !== 32'd100 || o_err_count !== 32'd0) begin
      miscompares++;
      $display("FAIL count_100: got bits=%0d errs=%0d, expected bits=100 errs=0",
               o_bit_count, o_err_count);
    end
  endtask

  task automatic test_single_error();
    rx_flip = 1;
    en_step(1, 0);
    vectors++;
    if (o_err_count !== 32'd1 || o_error_flag !== 1'b1 || obs !== expv()) begin
      miscompares++;
      $display("FAIL single_error: got errs=%0d flag=%b, expected errs=1 flag=1",
               o_err_count, o_error_flag);
    end
    for (int i = 0; i < 20; i++) begin
      en_step($urandom_range(1, 4), 0);
      vectors++;
      if (obs !== expv()) begin
        miscompares++;
        $display("FAIL after_error enable %0d: got %h, expected %h", i, obs, expv());
      end
    end
    vectors++;
    if (o_err_count !== 32'd1 || o_error_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL error_hold: got errs=%0d flag=%b, expected errs=1 flag=1",
               o_err_count, o_error_flag);
    end
  endtask

  task automatic test_clear();
    repeat (2) begin
      rx_flip = 1;
      en_step(2, 0);
    end
    vectors++;
    if (o_err_count !== 32'd3) begin
      miscompares++;
      $display("FAIL err_three: got %0d, expected 3", o_err_count);
    end
    en_step(1, 1);
    vectors++;
    if ({o_locked, o_delay, o_bit_count, o_err_count, o_error_flag} !== 70'h0) begin
      miscompares++;
      $display("FAIL clear: got locked=%b delay=%0d bits=%0d errs=%0d flag=%b, expected all 0",
               o_locked, o_delay, o_bit_count, o_err_count, o_error_flag);
    end
    for (int i = 0; i < MAXD * WIN; i++) begin
      en_step($urandom_range(1, 3), 0);
      vectors++;
      if (obs !== expv()) begin
        miscompares++;
        $display("FAIL relock enable %0d: got %h, expected %h", i, obs, expv());
      end
    end
    vectors++;
    if ({o_locked, o_delay} !== {1'b1, 4'd5}) begin
      miscompares++;
      $display("FAIL relock_delay: got locked=%b delay=%0d, expected locked=1 delay=5",
               o_locked, o_delay);
    end
  endtask

  task automatic test_saturation();
    rx_invert = 1;
    for (int i = 0; i < 40; i++) begin
      en_step(1, 0);
      vectors++;
      if (obs !== expv()) begin
        miscompares++;
        $display("FAIL saturate enable %0d: got %h, expected %h", i, obs, expv());
      end
    end
    for (int i = 0; i < 20; i++) begin
      en_step($urandom_range(1, 2), 0);
      vectors++;
      if (o_bit_count4 !== 4'd15 || o_err_count4 !== 4'd15 || obs !== expv()) begin
        miscompares++;
        $display("FAIL saturate_hold enable %0d: got bits=%0d errs=%0d, expected 15 15",
                 i, o_bit_count4, o_err_count4);
      end
    end
  endtask

  task automatic test_delay_change();
    rx_invert = 0;
    tx_delay  = 3;
`ifdef BER_RELOCK_EN
    begin
      int k;
      k = 0;
      do begin
        en_step(1, 0);
        k++;
        vectors++;
        if (obs !== expv()) begin
          miscompares++;
          $display("FAIL unlock enable %0d: got %h, expected %h", k, obs, expv());
        end
      end while (o_locked === 1'b1 && k < WIN);
      vectors++;
      if (o_locked !== 1'b0) begin
        miscompares++;
        $display("FAIL unlock_timeout: got locked=%b after %0d enables, expected 0", o_locked, k);
      end
      for (int i = 0; i < MAXD * WIN; i++) begin
        en_step(1, 0);
        vectors++;
        if (obs !== expv()) begin
          miscompares++;
          $display("FAIL rescan enable %0d: got %h, expected %h", i, obs, expv());
        end
      end
      vectors++;
      if ({o_locked, o_delay} !== {1'b1, 4'd3}) begin
        miscompares++;
        $display("FAIL relock_at_3: got locked=%b delay=%0d, expected locked=1 delay=3",
                 o_locked, o_delay);
      end
    end
`else
    begin
      logic [31:0] prev;
      prev = o_err_count;
      for (int i = 0; i < 200; i++) begin
        en_step(1, 0);
        vectors++;
        if (obs !== expv()) begin
          miscompares++;
          $display("FAIL hold_lock enable %0d: got %h, expected %h", i, obs, expv());
        end
      end
      vectors++;
      if (o_locked !== 1'b1 || o_delay !== 4'd5 || !(o_err_count > prev)) begin
        miscompares++;
        $display("FAIL hold_lock_end: got locked=%b delay=%0d errs=%0d, expected 1, 5, >%0d",
                 o_locked, o_delay, o_err_count, prev);
      end
    end
`endif
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if (obs !== 84'h0) begin
      miscompares++;
      $display("FAIL async_reset: got %h, expected 0", obs);
    end
    hist = '0;
    model_clear();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_rescan();
    tx_delay = 20;
    en_step(1, 1);
    for (int i = 0; i < 3 * MAXD * WIN; i++) begin
      en_step(1, 0);
      vectors++;
      if (obs !== expv()) begin
        miscompares++;
        $display("FAIL rescan_oor enable %0d: got %h, expected %h", i, obs, expv());
      end
    end
    vectors++;
    if (o_locked !== 1'b0) begin
      miscompares++;
      $display("FAIL out_of_range: got locked=%b, expected 0", o_locked);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    tx_delay = 0; rx_invert = 0; rx_flip = 0;
    test_reset();
    test_scan_lock();
    test_single_error();
    test_clear();
    test_saturation();
    test_delay_change();
    test_async_reset();
    test_rescan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ber_sync_counter.md
Name: ber_sync_counter

Overview:
Parametrised bit-error-rate checker for the PRBS/tx/rx link, one instance per I/Q rail. Compares received decisions against the local PRBS reference. Searches for the reference-to-received latency automatically over MAX_DELAY candidate offsets, then locks on the best one. After lock it accumulates saturating bit and error counts for readout. It replaces the fixed-alignment, flag-only checker.

Parameters:
MAX_DELAY, 16, number of candidate offsets 0..MAX_DELAY-1 in enable periods (>=2)
WINDOW, 128, enables counted per candidate during scan (>=1)
ERR_THRESH, 0, maximum best-window error count accepted for lock
CNT_W, 32, width of o_bit_count / o_err_count

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
i_enable  input  1  bit strobe, one clk wide, once per symbol
i_ref  input  1  local PRBS reference bit, valid when i_enable=1
i_rx  input  1  received decision bit, valid when i_enable=1
i_clear  input  1  synchronous restart: clears counters, restarts scan
o_locked  output  1  1 = alignment found, counting active
o_delay  output  $clog2(MAX_DELAY)  selected offset (valid when o_locked=1)
o_bit_count  output  CNT_W  bits compared since lock, saturating
o_err_count  output  CNT_W  errors since lock, saturating
o_error_flag  output  1  sticky: 1 once any error counted since lock

Behaviour:
- Reset (rst=0): delay line, all counters and all outputs = 0; state = SCAN; candidate d = 0; best_err = all ones.
- Delay line: MAX_DELAY-1 bit shift register that shifts i_ref on each i_enable. Candidate d compares i_rx against i_ref delayed by d enables; d=0 uses the current i_ref.
- States: SCAN and LOCK. All logic advances only on cycles with i_enable=1, except i_clear.
- SCAN:
  - Count mismatches at candidate d over WINDOW enables.
  - On the last enable of a window, compare the window count (including the mismatch on that enable) to best_err. If strictly less, update best_err and best_d. Ties keep the lower d.
  - Then d increments and the window counter clears.
  - After the window for d=MAX_DELAY-1 ends:
    - best_err <= ERR_THRESH: go to LOCK; o_delay = best_d; o_locked=1 on that same clock edge.
    - Otherwise: d=0, best_err = all ones, remain in SCAN (full rescan).
  - Full scan = MAX_DELAY*WINDOW enables.
- LOCK:
  - Each enable: o_bit_count += 1.
  - Mismatch at o_delay: o_err_count += 1 and o_error_flag=1. Outputs update on the same clk edge (registered, 1-cycle latency).
  - Both counters saturate at 2^CNT_W-1 independently and do not wrap.
  - o_error_flag clears only on reset or i_clear.
- i_clear=1 (any state, regardless of i_enable):
  - Next edge: counters, o_error_flag, o_locked, o_delay = 0; state = SCAN, d=0, best_err = all ones.
  - The delay line is not cleared.
  - i_clear has priority over a simultaneous i_enable. That enable is discarded except for its delay-line shift.
- Reset asserted mid-operation returns all state to the reset values asynchronously.

Optional Feature:
BER_RELOCK_EN
- Defined: in LOCK, a per-window error counter runs over WINDOW enables. If a window ends with errors > ERR_THRESH, the next edge behaves like i_clear: o_locked=0, counters cleared, rescan from d=0.
- Undefined: LOCK is held until reset or i_clear, whatever the error rate.

Test Plan:
1. Defaults; i_rx = i_ref delayed 5 enables, error-free, enable every 4 clks:
   - o_locked rises after exactly 2048 enables, o_delay=5.
   - o_err_count=0; o_bit_count=100 after 100 further enables.
2. i_rx = i_ref delayed 20 (out of range), PRBS9 data: best_err>0, so repeated rescans; o_locked stays 0 for 3 full scans.
3. Locked per scenario 1; flip one i_rx bit:
   - o_err_count=1 and o_error_flag=1 one clk after that enable.
   - Further clean bits leave o_err_count=1.
4. i_clear pulse while locked with o_err_count=3: next edge gives o_locked=0 and all counts 0. Relock at o_delay=5 after 2048 enables.
5. CNT_W=4, locked, i_rx inverted: both counters reach 15 and hold 15 for 20 further enables.
6. Locked at 5, then switch delay to 3:
   - With BER_RELOCK_EN: unlock within WINDOW enables, then relock with o_delay=3.
   - Without: o_locked stays 1, o_delay=5, o_err_count grows.
